seg7_scan_decoder: RTL and testbench

Receive-side counterpart of the digit-to-segment encoder in the clock display path. Samples a multiplexed common-anode 7-segment bus (anode select + active-low segments). It debounces each digit's dwell and decodes the segment pattern back to BCD, then presents a full frame of digits with a one-cycle valid pulse. Used as a display loopback monitor and as a checker for the time-keeping datapath.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_to_bcd.sv | 31 +++
 rtl/seg7_scan_decoder.sv | 169 ++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment tables and decoder state types.
// The encoder uses the same SEG_* constants so the two tables stay in sync.
package seg7_pkg;

    // Active-low segment patterns, bit6=a ... bit0=g
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_ERR   = 4'hE;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HELD
    } state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational active-low segment pattern to BCD code decoder.
// Blank maps to CODE_BLANK; anything unrecognised maps to CODE_ERR with err set.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] code_o,
    output logic       err_o
);

    // Table lookup with illegal-pattern fallback
    always_comb begin
        code_o = CODE_ERR;
        err_o  = 1'b1;
        case (seg_i)
            SEG_0:     begin code_o = 4'd0;       err_o = 1'b0; end
            SEG_1:     begin code_o = 4'd1;       err_o = 1'b0; end
            SEG_2:     begin code_o = 4'd2;       err_o = 1'b0; end
            SEG_3:     begin code_o = 4'd3;       err_o = 1'b0; end
            SEG_4:     begin code_o = 4'd4;       err_o = 1'b0; end
            SEG_5:     begin code_o = 4'd5;       err_o = 1'b0; end
            SEG_6:     begin code_o = 4'd6;       err_o = 1'b0; end
            SEG_7:     begin code_o = 4'd7;       err_o = 1'b0; end
            SEG_8:     begin code_o = 4'd8;       err_o = 1'b0; end
            SEG_9:     begin code_o = 4'd9;       err_o = 1'b0; end
            SEG_BLANK: begin code_o = CODE_BLANK; err_o = 1'b0; end
            default:   begin code_o = CODE_ERR;   err_o = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Multiplexed 7-segment bus monitor: debounces each digit dwell,
// decodes it back to BCD and reports complete frames with a valid pulse.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int STABLE_CYC = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    sample_en_i,
    input  logic [NUM_DIGITS-1:0]   an_i,
    input  logic [6:0]              seg_i,
    output logic [4*NUM_DIGITS-1:0] digits_o,
    output logic [NUM_DIGITS-1:0]   digit_err_o,
    output logic                    frame_valid_o,
    output logic                    frame_err_o
);

    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    state_e                  state_q, state_d;
    logic [NUM_DIGITS-1:0]   ref_an_q, ref_an_d;
    logic [6:0]              ref_seg_q, ref_seg_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   digit_err_q, digit_err_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    frame_err_q, frame_err_d;

    logic [NUM_DIGITS-1:0]   an_low;
    logic                    qual;
    logic                    same;
    logic                    capture;
    logic [IW-1:0]           ref_idx;
    logic [3:0]              dec_code;
    logic                    dec_err;

    seg7_to_bcd u_dec (
        .seg_i  (ref_seg_q),
        .code_o (dec_code),
        .err_o  (dec_err)
    );

    // Qualified sample: strobe present and exactly one anode driven low
    always_comb begin
        an_low = ~an_i;
        qual   = sample_en_i
               && (an_low != '0)
               && ((an_low & (an_low - NUM_DIGITS'(1))) == '0);
        same   = (an_i == ref_an_q) && (seg_i == ref_seg_q);
    end

    // Encode the slot index of the low bit in the reference anode word
    always_comb begin
        ref_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!ref_an_q[i]) ref_idx = IW'(i);
        end
    end

    // Dwell tracking FSM: next state, reference reload and run counter
    always_comb begin
        state_d   = state_q;
        ref_an_d  = ref_an_q;
        ref_seg_d = ref_seg_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        if (sample_en_i) begin
            unique case (state_q)
                IDLE: begin
                    if (qual) begin
                        ref_an_d  = an_i;
                        ref_seg_d = seg_i;
                        cnt_d     = CW'(1);
                        state_d   = TRACK;
                    end
                end
                TRACK: begin
                    if (!qual) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (same) begin
                        if (cnt_q != CW'(STABLE_CYC)) cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CW'(STABLE_CYC - 1)) begin
                            capture = 1'b1;
                            state_d = HELD;
                        end
                    end else begin
                        ref_an_d  = an_i;
                        ref_seg_d = seg_i;
                        cnt_d     = CW'(1);
                    end
                end
                HELD: begin
                    if (!qual) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (!same) begin
                        ref_an_d  = an_i;
                        ref_seg_d = seg_i;
                        cnt_d     = CW'(1);
                        state_d   = TRACK;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Capture registers, seen tracking and frame completion
    always_comb begin
        digits_d      = digits_q;
        digit_err_d   = digit_err_q;
        seen_d        = seen_q;
        frame_valid_d = 1'b0;
        frame_err_d   = frame_err_q;
        if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (IW'(i) == ref_idx) begin
                    digits_d[4*i +: 4] = dec_code;
                    digit_err_d[i]     = dec_err;
                    seen_d[i]          = 1'b1;
                end
            end
            if (&seen_d) begin
                frame_valid_d = 1'b1;
                frame_err_d   = |digit_err_d;
                seen_d        = '0;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            ref_an_q      <= '1;
            ref_seg_q     <= SEG_BLANK;
            cnt_q         <= '0;
            seen_q        <= '0;
            digits_q      <= {NUM_DIGITS{CODE_BLANK}};
            digit_err_q   <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ref_an_q      <= ref_an_d;
            ref_seg_q     <= ref_seg_d;
            cnt_q         <= cnt_d;
            seen_q        <= seen_d;
            digits_q      <= digits_d;
            digit_err_q   <= digit_err_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign digits_o      = digits_q;
    assign digit_err_o   = digit_err_q;
    assign frame_valid_o = frame_valid_q;
    assign frame_err_o   = frame_err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scans plus random dwells,
// compared each cycle against a run-length reference model.
module tb_seg7_scan_decoder;

    localparam int ND = 6;
    localparam int SC = 4;

    localparam logic [6:0] PAT [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    logic            clk = 1'b0;
    logic            rst_n;
    logic            sample_en;
    logic [ND-1:0]   an;
    logic [6:0]      seg;
    logic [4*ND-1:0] digits_o;
    logic [ND-1:0]   digit_err_o;
    logic            frame_valid_o;
    logic            frame_err_o;

    int errors = 0;
    int checks = 0;
    int dut_pulses = 0;
    logic prev_fv = 1'b0;

    // reference model state
    int         run_len;
    logic [5:0] last_an;
    logic [6:0] last_seg;
    logic [3:0] m_dig [ND];
    logic       m_err [ND];
    logic       m_seen [ND];
    logic       m_fv;
    logic       m_ferr;

    seg7_scan_decoder #(
        .NUM_DIGITS (ND),
        .STABLE_CYC (SC)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .sample_en_i   (sample_en),
        .an_i          (an),
        .seg_i         (seg),
        .digits_o      (digits_o),
        .digit_err_o   (digit_err_o),
        .frame_valid_o (frame_valid_o),
        .frame_err_o   (frame_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [23:0] got,
                         input logic [23:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        run_len = 0;
        last_an = '1;
        last_seg = '1;
        m_fv = 1'b0;
        m_ferr = 1'b0;
        for (int i = 0; i < ND; i++) begin
            m_dig[i] = 4'hF;
            m_err[i] = 1'b0;
            m_seen[i] = 1'b0;
        end
    endtask

    function automatic int zero_count(input logic [5:0] a);
        int n = 0;
        for (int i = 0; i < ND; i++) if (!a[i]) n++;
        return n;
    endfunction

    // Capture when a run of identical qualified strobes reaches SC exactly
    task automatic model_step(input bit en, input logic [5:0] a,
                              input logic [6:0] s);
        int k;
        logic [3:0] code;
        logic e;
        bit all;
        m_fv = 1'b0;
        if (!en) return;
        if (zero_count(a) != 1) begin
            run_len = 0;
            return;
        end
        if (run_len > 0 && a == last_an && s == last_seg) begin
            run_len++;
        end else begin
            run_len = 1;
            last_an = a;
            last_seg = s;
        end
        if (run_len != SC) return;
        k = 0;
        for (int i = 0; i < ND; i++) if (!a[i]) k = i;
        code = 4'hE;
        e = 1'b1;
        for (int v = 0; v < 10; v++) begin
            if (s == PAT[v]) begin
                code = 4'(v);
                e = 1'b0;
            end
        end
        if (s == 7'h7F) begin
            code = 4'hF;
            e = 1'b0;
        end
        m_dig[k] = code;
        m_err[k] = e;
        m_seen[k] = 1'b1;
        all = 1'b1;
        for (int i = 0; i < ND; i++) if (!m_seen[i]) all = 1'b0;
        if (all) begin
            m_fv = 1'b1;
            m_ferr = 1'b0;
            for (int i = 0; i < ND; i++) begin
                m_ferr |= m_err[i];
                m_seen[i] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        logic [23:0] dv;
        logic [23:0] ev;
        dv = '0;
        ev = '0;
        for (int i = 0; i < ND; i++) begin
            dv[4*i +: 4] = m_dig[i];
            ev[i] = m_err[i];
        end
        check("digits", digits_o, dv);
        check("digit_err", 24'(digit_err_o), ev);
        check("frame_valid", 24'(frame_valid_o), 24'(m_fv));
        check("frame_err", 24'(frame_err_o), 24'(m_ferr));
        if (frame_valid_o) begin
            dut_pulses++;
            check("fv_back_to_back", 24'(prev_fv), 24'd0);
        end
        prev_fv = frame_valid_o;
    endtask

    task automatic step(input bit en, input logic [5:0] a,
                        input logic [6:0] s);
        sample_en = en;
        an = a;
        seg = s;
        @(posedge clk);
        model_step(en, a, s);
        #1;
        compare_all();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        sample_en = 1'b0;
        an = '1;
        seg = '1;
        repeat (n) @(posedge clk);
        model_reset();
        #1;
        compare_all();
        rst_n = 1'b1;
    endtask

    task automatic dwell(input int k, input logic [6:0] s, input int n);
        logic [5:0] a;
        a = '1;
        a[k] = 1'b0;
        repeat (n) step(1'b1, a, s);
    endtask

    initial begin
        int p0;
        int k;
        int r;
        int len;
        logic [5:0] a;
        logic [6:0] s;

        rst_n = 1'b0;
        sample_en = 1'b0;
        an = '1;
        seg = '1;
        model_reset();

        // reset state
        do_reset(2);
        check("reset_digits", digits_o, 24'hFFFFFF);
        check("reset_fv", 24'(frame_valid_o), 24'd0);

        // clean frame 12:34:59
        p0 = dut_pulses;
        dwell(5, PAT[1], 4);
        dwell(4, PAT[2], 4);
        dwell(3, PAT[3], 4);
        dwell(2, PAT[4], 4);
        dwell(1, PAT[5], 4);
        dwell(0, PAT[9], 4);
        check("clean_pulses", 24'(dut_pulses - p0), 24'd1);
        check("clean_digits", digits_o, 24'h123459);
        check("clean_ferr", 24'(frame_err_o), 24'd0);
        step(1'b1, 6'h3F, 7'h7F);

        // debounce: 7 for 3 strobes then 8 for 4
        dwell(0, PAT[7], 3);
        check("debounce_no7", 24'(digits_o[3:0]), 24'd9);
        dwell(0, PAT[8], 4);
        check("debounce_8", 24'(digits_o[3:0]), 24'd8);

        // illegal pattern on digit 2 inside a full frame
        p0 = dut_pulses;
        dwell(5, PAT[0], 4);
        dwell(4, PAT[1], 4);
        dwell(3, PAT[2], 4);
        dwell(2, 7'b1111110, 4);
        dwell(1, PAT[3], 4);
        dwell(0, PAT[4], 4);
        check("illegal_pulses", 24'(dut_pulses - p0), 24'd1);
        check("illegal_err2", 24'(digit_err_o[2]), 24'd1);
        check("illegal_code", 24'(digits_o[11:8]), 24'hE);
        check("illegal_ferr", 24'(frame_err_o), 24'd1);

        // ghost and blanking gaps restart the dwell
        dwell(3, PAT[6], 2);
        step(1'b1, 6'b111111, 7'h7F);
        dwell(3, PAT[6], 2);
        step(1'b1, 6'b110011, PAT[6]);
        dwell(3, PAT[6], 3);
        check("ghost_no_cap", 24'(digits_o[15:12]), 24'd2);
        step(1'b0, 6'h3F, 7'h00);
        dwell(3, PAT[6], 1);
        check("ghost_hold_en", 24'(digits_o[15:12]), 24'd6);
        dwell(1, 7'h7F, 4);
        check("blank_code", 24'(digits_o[7:4]), 24'hF);
        check("blank_err", 24'(digit_err_o[1]), 24'd0);

        // mid-frame reset
        dwell(5, PAT[2], 4);
        dwell(4, PAT[3], 4);
        dwell(3, PAT[4], 4);
        dwell(2, PAT[5], 4);
        do_reset(1);
        p0 = dut_pulses;
        dwell(1, PAT[6], 4);
        dwell(0, PAT[7], 4);
        check("midreset_nopulse", 24'(dut_pulses - p0), 24'd0);
        for (int d = 5; d >= 0; d--) dwell(d, PAT[d], 4);
        check("midreset_one", 24'(dut_pulses - p0), 24'd1);

        // random dwells against the model
        for (int it = 0; it < 400; it++) begin
            k = $urandom_range(0, ND - 1);
            r = $urandom_range(0, 13);
            len = $urandom_range(1, 6);
            a = '1;
            a[k] = 1'b0;
            if (r < 10) s = PAT[r];
            else if (r == 10) s = 7'h7F;
            else s = 7'($urandom);
            if (r == 13) a = 6'($urandom);
            for (int j = 0; j < len; j++) begin
                step(($urandom_range(0, 4) != 0), a, s);
            end
            if ($urandom_range(0, 9) == 0) step(1'b1, 6'h3F, 7'h7F);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
